deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Receive-side counterpart of the audio Serializer: rebuilds parallel words from a serial bit stream qualified by a bit strobe.
- Gated by `enable` for word framing; delivers each word over a valid/ready handshake.
- Sits between the serial audio link and the sample-consuming logic, such as the timer/playback path or loopback checks.

Parameters:
- WIDTH, 16, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- enable  in  1  frame gate; high = receive active, low = abort/idle.
- audio_data  in  1  serial data bit.
- audio_enable  in  1  bit strobe; audio_data sampled on edges where enable=1 and audio_enable=1.
- data_out  out  WIDTH  last completed word, held stable while data_valid=1.
- data_valid  out  1  word available.
- data_ready  in  1  consumer accepts word when data_valid & data_ready.
- busy  out  1  high while a word is partially received.
- done  out  1  single-cycle pulse on the edge after each completed word, whether accepted or dropped.
- overrun  out  1  sticky flag: a completed word was dropped.
- overrun_clr  in  1  clears overrun.
- parity_error  out  1  see Optional Feature.

Behaviour:
- Reset (reset_n=0 at an edge), which overrides everything, including mid-word:
  - data_out=0, data_valid=0, busy=0, done=0, overrun=0, parity_error=0.
  - Bit counter=0, shift register=0, state=IDLE.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT on the first qualified strobe (enable & audio_enable); that bit is captured and counter becomes 1.
  - SHIFT: each qualified strobe captures one bit and increments counter.
  - On the strobe that captures bit number FRAME_LEN, the word completes, counter returns to 0 and state goes to IDLE.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
  - enable=0 in SHIFT: partial word discarded, counter=0, state=IDLE next edge. data_out, data_valid and overrun are unaffected. No done pulse.
- Strobes with enable=0 are ignored. The idle level of audio_data is irrelevant.
- busy = (state==SHIFT).
- Shift order: per MSB_FIRST. With MSB_FIRST=1 and sequence b0..b15, data_out = {b0,...,b15}.
- Completion edge (the edge capturing the last bit):
  - If data_valid=0, or data_valid & data_ready on that same edge: data_out <= assembled word, data_valid <= 1. The word is visible the cycle after the final strobe (latency 1).
  - Else (data_valid=1 & data_ready=0): word dropped, data_out unchanged, overrun <= 1.
  - In both cases done pulses high for exactly one cycle, on the cycle after the final strobe.
- Handshake:
  - data_valid falls on the edge where data_valid & data_ready, unless a new word completes on that same edge; then data_valid stays 1 with the new data.
  - data_ready while data_valid=0 has no effect.
- overrun_clr:
  - Clears overrun on the next edge.
  - If a drop occurs on the same edge as overrun_clr, the set wins (overrun stays 1).
- Back-to-back words: a qualified strobe on the cycle immediately after completion starts the next word. There is no dead cycle requirement.
- audio_enable held high continuously = one bit per clock; this must be supported.

Optional Feature:
- Macro: DESERIALIZER_PARITY_CHECK_EN.
- Defined:
  - FRAME_LEN = WIDTH+1; the extra final bit is an even-parity bit over the WIDTH data bits.
  - On completion, parity_error is loaded with (XOR of data bits and parity bit), alongside data_out, under the same accept/drop rules. A dropped word does not update parity_error.
  - parity_error has the same lifetime as data_out.
- Not defined:
  - FRAME_LEN = WIDTH.
  - parity_error is tied to constant 0.
  - No parity logic is synthesized.

Test Plan:
- Reset, then enable=1 with audio_enable high every clock and serial 1000_0000_0000_0001 MSB first -> after 16th strobe: data_out=16'h8001, data_valid=1, one-cycle done. data_ready=1 -> data_valid=0 next edge.
- Strobes every 4th clock with enable=0 for 40 strobes -> busy=0, data_valid=0, done never pulses. Then enable=1 and 16'hA5A5 -> data_out=16'hA5A5.
- data_ready held 0; send 16'h1234 then 16'hFFFF back-to-back -> data_out stays 16'h1234, overrun=1, two done pulses. Pulse overrun_clr -> overrun=0. Then data_ready=1 -> accepted.
- Send 7 bits, drop enable one cycle, then full 16'h00FF -> data_out=16'h00FF with no corruption from the partial bits. Repeat, asserting reset_n=0 after bit 9 -> all outputs 0.
- Accept/complete collision: data_valid=1 holding 16'h1111, data_ready=1 on the completion edge of 16'h2222 -> data_valid stays 1, data_out=16'h2222, overrun=0.
- With DESERIALIZER_PARITY_CHECK_EN: 16'h0003 + parity 0 -> parity_error=0. 16'h0007 + parity 0 -> parity_error=1. Without macro: 17-bit stream gives WIDTH-bit words and parity_error=0.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from strobed serial bits and offers them on a valid/ready handshake.
// Optional even-parity trailer bit enabled by defining DESERIALIZER_PARITY_CHECK_EN.
module deserializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             audio_data,
    input  logic             audio_enable,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_error
);

`ifdef DESERIALIZER_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_done;
    logic             r_overrun;
    logic             w_strobe;
    logic             w_last;
    logic             w_accept;

    assign w_strobe     = enable & audio_enable;
    assign w_last       = w_strobe && (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_accept     = !r_valid || data_ready;
    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], audio_data}
                                    : {audio_data, r_shift[WIDTH-1:1]};

`ifdef DESERIALIZER_PARITY_CHECK_EN
    // The trailing strobe carries the parity bit, so the data word is already complete in r_shift.
    logic r_perr;
    logic w_perr;
    assign w_word       = r_shift;
    assign w_perr       = (^r_shift) ^ audio_data;
    assign parity_error = r_perr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perr <= 1'b0;
        end else if (w_last && w_accept) begin
            r_perr <= w_perr;
        end
    end
`else
    assign w_word       = w_shift_next;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_strobe) w_state_next = SHIFT;
            SHIFT: if (!enable || w_last) w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (!enable || w_last) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_strobe) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= w_shift_next;
        end
    end

    // A completing word replaces the held one only if the slot is empty or being drained this edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last && w_accept) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
            if (w_last && !w_accept) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (WIDTH=16, MSB first); parity tests follow DESERIALIZER_PARITY_CHECK_EN.
module tb_deserializer;

    localparam int WIDTH = 16;
`ifdef DESERIALIZER_PARITY_CHECK_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             audio_data;
    logic             audio_enable;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             done;
    logic             overrun;
    logic             overrun_clr;
    logic             parity_error;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .audio_data(audio_data),
        .audio_enable(audio_enable), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .busy(busy), .done(done), .overrun(overrun),
        .overrun_clr(overrun_clr), .parity_error(parity_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Serial frame for a data word: data bits MSB first, then the even-parity bit (inverted when flip=1) if parity is built in.
    function automatic logic [31:0] frame(input logic [15:0] w, input logic flip);
`ifdef DESERIALIZER_PARITY_CHECK_EN
        return {15'b0, w, (^w) ^ flip};
`else
        return {16'b0, w ^ {15'b0, flip & 1'b0}};
`endif
    endfunction

    task automatic send_bits(input logic [31:0] w, input int n, input int gap,
                             input logic rdy_last, input logic clr_last);
        for (int i = n - 1; i >= 0; i--) begin
            if (i != n - 1) repeat (gap) tick();
            audio_data   = w[i];
            audio_enable = 1'b1;
            if (i == 0) begin
                data_ready  = rdy_last;
                overrun_clr = clr_last;
            end
            tick();
            audio_enable = 1'b0;
            data_ready   = 1'b0;
            overrun_clr  = 1'b0;
        end
    endtask

    task automatic consume();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; audio_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            audio_data = 1'($urandom);
            tick();
        end
        audio_enable = 1'b0;
        total++; if (data_out !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", parity_error); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        enable = 1'b1;
        send_bits(frame(16'h8001, 1'b0), FLEN, 0, 1'b0, 1'b0);
        total++; if (data_out !== 16'h8001) begin bad++; $display("FAIL basic_data: got %h want 8001", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", data_valid); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_hold: got %b want 1", data_valid); end
        consume();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_accept: got %b want 0", data_valid); end
    endtask

    task automatic test_disabled();
        int d0;
        logic seen_busy;
        d0 = done_cnt;
        seen_busy = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            audio_data = 1'($urandom);
            audio_enable = 1'b1;
            tick();
            audio_enable = 1'b0;
            if (busy !== 1'b0) seen_busy = 1'b1;
            repeat (3) tick();
        end
        total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL dis_busy: got %b want 0", seen_busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL dis_valid: got %b want 0", data_valid); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL dis_done: got %0d pulses want 0", done_cnt - d0); end
        enable = 1'b1;
        send_bits(frame(16'hA5A5, 1'b0), FLEN, 1, 1'b0, 1'b0);
        total++; if (data_out !== 16'hA5A5) begin bad++; $display("FAIL dis_a5a5: got %h want a5a5", data_out); end
        consume();
    endtask

    task automatic test_overrun();
        int d0;
        d0 = done_cnt;
        send_bits(frame(16'h1234, 1'b0), FLEN, 0, 1'b0, 1'b0);
        send_bits(frame(16'hFFFF, 1'b0), FLEN, 0, 1'b0, 1'b0);
        total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ovr_data: got %h want 1234", data_out); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ovr_drop_done: got %b want 1", done); end
        tick();
        total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL ovr_done_cnt: got %0d want 2", done_cnt - d0); end
        send_bits(frame(16'hBEEF, 1'b0), FLEN, 0, 1'b0, 1'b1);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL ovr_still_valid: got %b want 1", data_valid); end
        consume();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept: got %b want 0", data_valid); end
        total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ovr_hold: got %h want 1234", data_out); end
    endtask

    task automatic test_abort();
        send_bits(32'($urandom), 7, 0, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy); end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", busy); end
        send_bits(frame(16'h00FF, 1'b0), FLEN, 0, 1'b0, 1'b0);
        total++; if (data_out !== 16'h00FF) begin bad++; $display("FAIL abort_data: got %h want 00ff", data_out); end
        send_bits(frame(16'h5555, 1'b0), FLEN, 0, 1'b0, 1'b0);
        send_bits(32'($urandom), 9, 1, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (data_out !== 16'h0) begin bad++; $display("FAIL rst_mid_data: got %h want 0000", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", data_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        send_bits(frame(16'h0F0F, 1'b0), FLEN, 0, 1'b0, 1'b0);
        total++; if (data_out !== 16'h0F0F) begin bad++; $display("FAIL rst_mid_next: got %h want 0f0f", data_out); end
        consume();
    endtask

    task automatic test_collision();
        send_bits(frame(16'h1111, 1'b0), FLEN, 0, 1'b0, 1'b0);
        send_bits(frame(16'h2222, 1'b0), FLEN, 1, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL coll_valid: got %b want 1", data_valid); end
        total++; if (data_out !== 16'h2222) begin bad++; $display("FAIL coll_data: got %h want 2222", data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL coll_overrun: got %b want 0", overrun); end
        consume();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL coll_accept: got %b want 0", data_valid); end
    endtask

    task automatic test_parity();
`ifdef DESERIALIZER_PARITY_CHECK_EN
        send_bits({15'b0, 16'h0003, 1'b0}, 17, 0, 1'b0, 1'b0);
        total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL par_good: got %b want 0", parity_error); end
        total++; if (data_out !== 16'h0003) begin bad++; $display("FAIL par_good_data: got %h want 0003", data_out); end
        consume();
        send_bits({15'b0, 16'h0007, 1'b0}, 17, 0, 1'b0, 1'b0);
        total++; if (parity_error !== 1'b1) begin bad++; $display("FAIL par_bad: got %b want 1", parity_error); end
        total++; if (data_out !== 16'h0007) begin bad++; $display("FAIL par_bad_data: got %h want 0007", data_out); end
        send_bits({15'b0, 16'h0003, 1'b0}, 17, 0, 1'b0, 1'b0);
        total++; if (parity_error !== 1'b1) begin bad++; $display("FAIL par_drop_keep: got %b want 1", parity_error); end
        overrun_clr = 1'b1;
        consume();
        overrun_clr = 1'b0;
`else
        send_bits({15'b0, 16'h1234, 1'b1}, 17, 0, 1'b0, 1'b0);
        total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL nopar_data: got %h want 1234", data_out); end
        total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL nopar_perr: got %b want 0", parity_error); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nopar_next_word: got %b want 1", busy); end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        consume();
`endif
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [15:0] exp_data;
        logic        exp_valid;
        logic        exp_ov;
        logic        exp_perr;
        logic        flip;
        int          gap;
        exp_data = 16'h0F0F; exp_valid = 1'b0; exp_ov = 1'b0; exp_perr = 1'b0;
        for (int it = 0; it < 30; it++) begin
            w = 16'($urandom);
            gap = $urandom_range(0, 2);
`ifdef DESERIALIZER_PARITY_CHECK_EN
            flip = 1'($urandom);
`else
            flip = 1'b0;
`endif
            if ($urandom_range(0, 3) == 0) begin
                send_bits(32'($urandom), $urandom_range(1, FLEN - 1), gap, 1'b0, 1'b0);
                enable = 1'b0;
                tick();
                enable = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) begin
                consume();
                exp_valid = 1'b0;
            end
            send_bits(frame(w, flip), FLEN, gap, 1'b0, 1'b0);
            if (exp_valid) begin
                exp_ov = 1'b1;
            end else begin
                exp_valid = 1'b1;
                exp_data  = w;
                exp_perr  = flip;
            end
            total++; if (data_out !== exp_data) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", it, data_out, exp_data); end
            total++; if (data_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", it, data_valid, exp_valid); end
            total++; if (overrun !== exp_ov) begin bad++; $display("FAIL rnd_overrun[%0d]: got %b want %b", it, overrun, exp_ov); end
            total++; if (parity_error !== exp_perr) begin bad++; $display("FAIL rnd_perr[%0d]: got %b want %b", it, parity_error, exp_perr); end
            total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd_done[%0d]: got %b want 1", it, done); end
            if ($urandom_range(0, 4) == 0) begin
                overrun_clr = 1'b1;
                tick();
                overrun_clr = 1'b0;
                exp_ov = 1'b0;
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rnd_clr[%0d]: got %b want 0", it, overrun); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; audio_data = 1'b0; audio_enable = 1'b0;
        data_ready = 1'b0; overrun_clr = 1'b0;
        test_reset();
        test_basic();
        test_disabled();
        test_overrun();
        test_abort();
        test_collision();
        test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
